// File: rtl/vote_session_ctrl_if.sv
// Handshake bundle between the voter front end / vote circuit and the session controller.
// The master side drives the session controls, the vote strobes and the vote circuit's P output.
interface vote_session_ctrl_if;
    logic       start;
    logic       clear;
    logic [3:0] btn;
    logic [3:0] yes;
    logic       p_in;
    logic [3:0] vote;
    logic [3:0] voted;
    logic       busy;
    logic       done;
    logic       result;

    modport master (
        output start, clear, btn, yes, p_in,
        input  vote, voted, busy, done, result
    );

    modport slave (
        input  start, clear, btn, yes, p_in,
        output vote, voted, busy, done, result
    );
endinterface

// File: rtl/vote_session_ctrl.sv
// Voting-session controller: opens a window, latches one vote per voter, closes on
// all-voted or timeout, drives the vote circuit and captures its P output into RESULT.
module vote_session_ctrl #(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    vote_session_ctrl_if.slave    s_bus
);
    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_EVAL, S_HOLD} state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_lat;
    logic [3:0]    r_vote;
    logic [3:0]    r_voted;
    logic          r_busy;
    logic          r_done;
    logic          r_result;

    logic [3:0]    w_acc;
    logic [3:0]    w_lat_nxt;
    logic [3:0]    w_voted_nxt;
    logic          w_close;

    // Only first presses are accepted; a close decision includes this cycle's presses.
    assign w_acc       = s_bus.btn & ~r_voted;
    assign w_lat_nxt   = (r_lat & ~w_acc) | (s_bus.yes & w_acc);
    assign w_voted_nxt = r_voted | w_acc;
    assign w_close     = (&w_voted_nxt) || (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_lat    <= '0;
            r_vote   <= '0;
            r_voted  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (s_bus.start) begin
                        r_state <= S_OPEN;
                        r_lat   <= '0;
                        r_voted <= '0;
                        r_vote  <= '0;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_OPEN: begin
                    r_lat   <= w_lat_nxt;
                    r_voted <= w_voted_nxt;
                    if (w_close) begin
                        // Votes become visible only now, giving the vote circuit one settle cycle.
                        r_state <= S_EVAL;
                        r_vote  <= w_lat_nxt;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_EVAL: begin
                    r_result <= s_bus.p_in;
                    r_state  <= S_HOLD;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                S_HOLD: begin
                    if (s_bus.start) begin
                        r_state <= S_OPEN;
                        r_lat   <= '0;
                        r_voted <= '0;
                        r_vote  <= '0;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end else if (s_bus.clear) begin
                        r_state  <= S_IDLE;
                        r_vote   <= '0;
                        r_voted  <= '0;
                        r_result <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_bus.vote   = r_vote;
    assign s_bus.voted  = r_voted;
    assign s_bus.busy   = r_busy;
    assign s_bus.done   = r_done;
    assign s_bus.result = r_result;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: directed scenarios with literal expectations, then
// randomized sessions checked every cycle against a behavioural session model.
module tb_vote_session_ctrl;
    localparam int TIMEOUT = 8;
    localparam int TW      = 4;

    localparam int P_IDLE = 0;
    localparam int P_OPEN = 1;
    localparam int P_EVAL = 2;
    localparam int P_HOLD = 3;

    typedef struct packed {
        int         ph;
        int         t;
        logic [3:0] lat;
        logic [3:0] voted;
        logic [3:0] vote;
        logic       busy;
        logic       done;
        logic       res;
    } mst_t;

    logic clk;
    logic rst_n;
    int   ncmp = 0;
    int   nerr = 0;
    bit   cmp_en = 0;
    mst_t m = '0;

    vote_session_ctrl_if bus ();

    vote_session_ctrl #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_bus   (bus.slave)
    );

    // Vote circuit stand-in: P is a strict majority (3 or more yes votes).
    function automatic logic vc(input logic [3:0] v);
        return ($countones(v) >= 3);
    endfunction

    assign bus.p_in = vc(bus.vote);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mst_t step(input mst_t s, input logic st, input logic cl,
                                  input logic [3:0] b, input logic [3:0] y);
        mst_t n = s;
        n.done = 1'b0;
        case (s.ph)
            P_IDLE: if (st) begin
                n.ph = P_OPEN; n.lat = '0; n.voted = '0; n.vote = '0; n.t = 0;
            end
            P_OPEN: begin
                for (int i = 0; i < 4; i++)
                    if (b[i] && !s.voted[i]) begin
                        n.voted[i] = 1'b1;
                        n.lat[i]   = y[i];
                    end
                if (n.voted == 4'hF || s.t == TIMEOUT - 1) begin
                    n.ph = P_EVAL; n.vote = n.lat;
                end else n.t = s.t + 1;
            end
            P_EVAL: begin
                n.res = vc(s.vote); n.ph = P_HOLD; n.done = 1'b1;
            end
            default: begin
                if (st) begin
                    n.ph = P_OPEN; n.lat = '0; n.voted = '0; n.vote = '0; n.t = 0;
                end else if (cl) begin
                    n.ph = P_IDLE; n.vote = '0; n.voted = '0; n.res = 1'b0;
                end
            end
        endcase
        n.busy = (n.ph == P_OPEN) || (n.ph == P_EVAL);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, bus.start, bus.clear, bus.btn, bus.yes);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            ncmp++;
            if ({bus.vote, bus.voted, bus.busy, bus.done, bus.result} !==
                {m.vote, m.voted, m.busy, m.done, m.res}) begin
                nerr++;
                $display("FAIL model t=%0t: vote/voted/busy/done/result got %b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                         $time, bus.vote, bus.voted, bus.busy, bus.done, bus.result,
                         m.vote, m.voted, m.busy, m.done, m.res);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic cl, input logic [3:0] b, input logic [3:0] y);
        bus.start = st; bus.clear = cl; bus.btn = b; bus.yes = y;
        @(posedge clk);
        #2;
        bus.start = 1'b0; bus.clear = 1'b0; bus.btn = '0; bus.yes = '0;
    endtask

    function automatic int outs();
        return {bus.vote, bus.voted, bus.busy, bus.done, bus.result};
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.clear = 1'b0; bus.btn = '0; bus.yes = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Four voters on consecutive cycles -> vote 1011, P=1
        cyc(1, 0, 4'h0, 4'h0);
        chk("open_busy", bus.busy, 1);
        cyc(0, 0, 4'h1, 4'h1);
        cyc(0, 0, 4'h2, 4'h2);
        cyc(0, 0, 4'h4, 4'h0);
        chk("open_vote_hidden", bus.vote, 4'h0);
        cyc(0, 0, 4'h8, 4'h8);
        chk("eval_vote", bus.vote, 4'hB);
        chk("eval_voted", bus.voted, 4'hF);
        chk("eval_done_low", bus.done, 0);
        cyc(0, 0, 4'h0, 4'h0);
        chk("hold_done", bus.done, 1);
        chk("hold_result", bus.result, 1);
        chk("hold_busy", bus.busy, 0);
        cyc(0, 0, 4'h0, 4'h0);
        chk("done_one_pulse", bus.done, 0);

        // START and CLEAR together in HOLD: START wins, RESULT retained
        cyc(1, 1, 4'h0, 4'h0);
        chk("restart_busy", bus.busy, 1);
        chk("restart_result_kept", bus.result, 1);
        chk("restart_voted_clr", bus.voted, 4'h0);

        // Repeat vote by W ignored
        cyc(0, 0, 4'h1, 4'h1);
        cyc(0, 0, 4'h1, 4'h0);
        cyc(0, 0, 4'h6, 4'h6);
        cyc(0, 0, 4'h8, 4'h0);
        chk("repeat_vote", bus.vote, 4'h7);
        cyc(0, 0, 4'h0, 4'h0);
        chk("repeat_result", bus.result, 1);
        cyc(0, 1, 4'h0, 4'h0);
        chk("clear_to_idle", outs(), 0);
        cyc(0, 1, 4'hF, 4'hF);
        chk("idle_ignores_clear_btn", outs(), 0);

        // Timeout: only X votes yes at timer==2
        cyc(1, 0, 4'h0, 4'h0);
        cyc(0, 0, 4'h0, 4'h0);
        cyc(0, 0, 4'h0, 4'h0);
        cyc(0, 0, 4'h2, 4'h2);
        repeat (4) cyc(0, 0, 4'h0, 4'h0);
        chk("timeout_still_open", {bus.busy, bus.vote, bus.voted}, {1'b1, 4'h0, 4'h2});
        cyc(0, 0, 4'h0, 4'h0);
        chk("timeout_eval", {bus.busy, bus.vote, bus.voted}, {1'b1, 4'h2, 4'h2});
        cyc(0, 0, 4'h0, 4'h0);
        chk("timeout_hold", {bus.done, bus.result}, 2'b10);

        // All four in one cycle
        cyc(1, 0, 4'h0, 4'h0);
        cyc(0, 0, 4'hF, 4'h5);
        chk("simul_eval", {bus.busy, bus.vote, bus.voted}, {1'b1, 4'h5, 4'hF});
        cyc(0, 0, 4'h0, 4'h0);
        chk("simul_result", bus.result, 0);

        // Async reset mid-OPEN with two votes latched
        cyc(1, 0, 4'h0, 4'h0);
        cyc(0, 0, 4'h3, 4'h3);
        chk("pre_reset_voted", bus.voted, 4'h3);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(0, 0, 4'h0, 4'h0);
        chk("idle_after_reset", outs(), 0);
        cyc(1, 0, 4'h0, 4'h0);
        chk("start_after_reset", bus.busy, 1);

        // Randomized sessions
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
